step_dir_receiver: RTL

- Receiver end of the step/dir interface driven by the DDA step generator. Decodes an external step/direction pair into a signed position count and a step-interval measurement.
- Sits behind the encoder/feedback pins. Used for loopback verification of the motion core and for slaved-axis following.
- Synchronizes and glitch-filters the asynchronous inputs.
- Outputs per-step event pulses, the measured period between steps and a stall flag.

---
 rtl/step_dir_receiver.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/step_dir_receiver.sv
// Step/direction receiver: synchronizes and glitch-filters an external step/dir pair, then
// tracks a signed position, the interval between accepted steps and a stall indication.
module step_dir_receiver #(
  parameter int unsigned POS_BITS      = 64,
  parameter int unsigned PERIOD_BITS   = 32,
  parameter int unsigned FILTER_CYCLES = 2
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   step_in,
  input  logic                   dir_in,
  input  logic                   enable,
  input  logic                   load_pos,
  input  logic [POS_BITS-1:0]    load_value,
  output logic [POS_BITS-1:0]    position,
  output logic                   step_seen,
  output logic                   step_dir,
  output logic [PERIOD_BITS-1:0] period,
  output logic                   period_valid,
  output logic                   stalled
);

  localparam logic [7:0]             FiltCount = 8'(FILTER_CYCLES);
  localparam logic [PERIOD_BITS-1:0] TimerMax  = '1;

  typedef enum logic [1:0] {StArmed, StQual, StRelease} state_e;

  state_e                 state_q, state_d;
  logic [7:0]             qcount_q, qcount_d;
  logic                   step_meta_q, step_sync_q;
  logic                   dir_meta_q, dir_sync_q;
  logic                   enable_q;
  logic                   first_step_q, first_step_d;
  logic [PERIOD_BITS-1:0] timer_q, timer_d;
  logic [PERIOD_BITS-1:0] period_q, period_d;
  logic                   period_valid_q, period_valid_d;
  logic                   step_seen_q, step_seen_d;
  logic                   step_dir_q, step_dir_d;
  logic [POS_BITS-1:0]    position_q, position_d;

  logic accept;
  logic en_accept;
  logic first_eff;

  // Filter: a step is accepted on the edge that sees the FILTER_CYCLES-th consecutive high sample.
  always_comb begin
    state_d  = state_q;
    qcount_d = qcount_q;
    accept   = 1'b0;
    unique case (state_q)
      StArmed: begin
        if (step_sync_q) begin
          if (FiltCount == 8'd1) begin
            accept  = 1'b1;
            state_d = StRelease;
          end else begin
            state_d  = StQual;
            qcount_d = 8'd1;
          end
        end
      end
      StQual: begin
        if (!step_sync_q) begin
          state_d = StArmed;
        end else if (qcount_q + 8'd1 == FiltCount) begin
          accept  = 1'b1;
          state_d = StRelease;
        end else begin
          qcount_d = qcount_q + 8'd1;
        end
      end
      StRelease: begin
        if (!step_sync_q) state_d = StArmed;
      end
      default: state_d = StArmed;
    endcase
  end

  // An enable rising edge counts as a fresh start even if it coincides with an accept.
  assign en_accept = accept & enable;
  assign first_eff = first_step_q | (enable & ~enable_q);

  always_comb begin
    step_seen_d    = en_accept;
    period_valid_d = en_accept & ~first_eff;
    step_dir_d     = en_accept ? dir_sync_q : step_dir_q;
    period_d       = (en_accept && !first_eff) ? timer_q : period_q;
    first_step_d   = en_accept ? 1'b0 : first_eff;

    if (en_accept) begin
      timer_d = PERIOD_BITS'(1);
    end else if (timer_q == TimerMax) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + PERIOD_BITS'(1);
    end

    if (load_pos) begin
      position_d = load_value;
    end else if (en_accept) begin
      position_d = dir_sync_q ? position_q + POS_BITS'(1) : position_q - POS_BITS'(1);
    end else begin
      position_d = position_q;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q        <= StArmed;
      qcount_q       <= 8'd0;
      step_meta_q    <= 1'b0;
      step_sync_q    <= 1'b0;
      dir_meta_q     <= 1'b0;
      dir_sync_q     <= 1'b0;
      enable_q       <= 1'b0;
      first_step_q   <= 1'b1;
      timer_q        <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      step_seen_q    <= 1'b0;
      step_dir_q     <= 1'b0;
      position_q     <= '0;
    end else begin
      state_q        <= state_d;
      qcount_q       <= qcount_d;
      step_meta_q    <= step_in;
      step_sync_q    <= step_meta_q;
      dir_meta_q     <= dir_in;
      dir_sync_q     <= dir_meta_q;
      enable_q       <= enable;
      first_step_q   <= first_step_d;
      timer_q        <= timer_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      step_seen_q    <= step_seen_d;
      step_dir_q     <= step_dir_d;
      position_q     <= position_d;
    end
  end

  assign position     = position_q;
  assign step_seen    = step_seen_q;
  assign step_dir     = step_dir_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign stalled      = (timer_q == TimerMax);

endmodule
